// File: rtl/dmux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Slot state encoding, drop counter width and a constant-foldable clog2.
package dmux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int DROP_CNT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry output slot: loaded data is visible the next cycle (latency 1).
// A drain and a load on the same edge keep the slot FULL with the new payload.
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = d;
    end else if (drain) begin
      // Draining an EMPTY slot leaves it EMPTY; data is held for consumers to ignore.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign q    = data_q;
  assign full = (state_q == FULL);

endmodule

// File: rtl/dmux_stream.sv
// Valid/ready demux into CHANNELS one-entry slots, unicast or broadcast, latency 1.
// in_ready is combinational on out_ready; out-of-range selectors are dropped and counted.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      err,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic [CHANNELS-1:0]   slot_full;
  logic [CHANNELS-1:0]   slot_free;
  logic [SEL_SPAN-1:0]   free_pad;
  logic [CHANNELS-1:0]   load;
  logic                  in_range;
  logic                  accept;
  logic                  drop;
  logic                  err_q,      err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    slot_free = ~slot_full | out_ready;
    // Pad so an out-of-range selector still indexes a defined bit.
    free_pad                 = '0;
    free_pad[CHANNELS-1:0]   = slot_free;
    in_range = int'(in_sel) < CHANNELS;

    if (in_bcast)      in_ready = &slot_free;
    else if (in_range) in_ready = free_pad[in_sel];
    else               in_ready = 1'b1;

    accept = in_valid && in_ready;
    drop   = accept && !in_bcast && !in_range;

    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = accept && (in_bcast || (in_range && (in_sel == SEL_W'(i))));
    end
  end

  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .drain (out_ready[g]),
      .d     (in_data),
      .q     (out_data[g*WIDTH +: WIDTH]),
      .full  (slot_full[g])
    );
  end

  assign out_valid  = slot_full;
  assign err        = err_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: 8-channel instance for data paths, 6-channel for drops.
// Expected payloads are queued at issue time and matched by a monitor on each drain.
module tb_dmux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v8, r8, b8, e8;
  logic [15:0] d8;
  logic [2:0]  s8;
  logic [7:0]  ov8, or8, dc8;
  logic [127:0] od8;

  logic        v6, r6, b6, e6;
  logic [15:0] d6;
  logic [2:0]  s6;
  logic [5:0]  ov6, or6;
  logic [7:0]  dc6;
  logic [95:0] od6;

  dmux_stream #(.WIDTH(16), .CHANNELS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_data(d8),
    .in_sel(s8), .in_bcast(b8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .err(e8), .drop_count(dc8)
  );

  dmux_stream #(.WIDTH(16), .CHANNELS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_data(d6),
    .in_sel(s6), .in_bcast(b6), .out_valid(ov6), .out_ready(or6),
    .out_data(od6), .err(e6), .drop_count(dc6)
  );

  typedef struct {
    int          ch;
    logic [15:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] slot8(input int i);
    return od8[i*16 +: 16];
  endfunction

  task automatic push(input int ch, input logic [15:0] dat);
    exp_t e;
    e.ch  = ch;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [2:0] s, input logic [15:0] d, input logic b);
    v8 = v; s8 = s; d8 = d; b8 = b;
  endtask

  // A drain happens on the edge after a negedge where valid and ready are both high.
  task automatic monitor_loop();
    int idx;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 8; i++) begin
          if (ov8[i] && or8[i]) begin
            idx = -1;
            foreach (exp_q[j]) if (idx < 0 && exp_q[j].ch == i) idx = j;
            if (idx < 0) begin
              check("sb_unexpected_drain", 64'(i), 64'hFFFF);
            end else begin
              check("sb_data", 64'(slot8(i)), 64'(exp_q[idx].dat));
              exp_q.delete(idx);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, ec;
    rst_n = 1'b0;
    drive8(1'b0, 3'd0, 16'h0, 1'b0);
    or8 = '0;
    v6 = 1'b0; s6 = '0; d6 = '0; b6 = 1'b0; or6 = '0;
    fork monitor_loop(); join_none

    #2;
    check("rst_out_valid", 64'(ov8), 64'h0);
    check("rst_out_data",  64'(od8[63:0]), 64'h0);
    check("rst_err",       64'(e8), 64'h0);
    check("rst_drop_cnt",  64'(dc8), 64'h0);
    #15 rst_n = 1'b1;
    step();

    // Unicast to an idle channel, then a second send is blocked.
    drive8(1'b1, 3'd3, 16'h1234, 1'b0);
    @(negedge clk);
    check("uc_ready", 64'(r8), 64'h1);
    push(3, 16'h1234);
    step();
    drive8(1'b1, 3'd3, 16'h5555, 1'b0);
    @(negedge clk);
    check("uc_out_valid", 64'(ov8), 64'h08);
    check("uc_out_data",  64'(slot8(3)), 64'h1234);
    check("uc_blocked",   64'(r8), 64'h0);
    step();
    drive8(1'b0, 3'd0, 16'h0, 1'b0);
    or8 = 8'h08;
    step();
    or8 = '0;
    @(negedge clk);
    check("uc_drained", 64'(ov8), 64'h0);

    // Pass-through: full slot with consumer ready accepts a new payload.
    step();
    drive8(1'b1, 3'd5, 16'hAAAA, 1'b0);
    push(5, 16'hAAAA);
    step();
    drive8(1'b1, 3'd5, 16'hBBBB, 1'b0);
    or8 = 8'h20;
    @(negedge clk);
    check("pt_ready", 64'(r8), 64'h1);
    push(5, 16'hBBBB);
    step();
    drive8(1'b0, 3'd0, 16'h0, 1'b0);
    or8 = '0;
    @(negedge clk);
    check("pt_out_valid", 64'(ov8[5]), 64'h1);
    check("pt_out_data",  64'(slot8(5)), 64'hBBBB);
    step();
    or8 = 8'h20;
    step();
    or8 = '0;

    // Broadcast blocked by one stuck slot, then released by draining it.
    drive8(1'b1, 3'd2, 16'h0222, 1'b0);
    push(2, 16'h0222);
    step();
    drive8(1'b1, 3'd6, 16'h00FF, 1'b1);
    @(negedge clk);
    check("bc_blocked", 64'(r8), 64'h0);
    step();
    @(negedge clk);
    check("bc_no_load", 64'(ov8), 64'h04);
    step();
    or8 = 8'h04;
    @(negedge clk);
    check("bc_ready", 64'(r8), 64'h1);
    for (int i = 0; i < 8; i++) push(i, 16'h00FF);
    step();
    drive8(1'b0, 3'd0, 16'h0, 1'b0);
    or8 = '0;
    @(negedge clk);
    check("bc_out_valid", 64'(ov8), 64'hFF);
    for (int i = 0; i < 8; i++) check("bc_out_data", 64'(slot8(i)), 64'h00FF);
    step();
    or8 = 8'hFF;
    step();
    or8 = '0;
    @(negedge clk);
    check("bc_drained", 64'(ov8), 64'h0);

    // Out-of-range selector on the 6-channel instance: 300 drops, counter saturates.
    check("drop_err_idle", 64'(e6), 64'h0);
    step();
    nr = 0;
    ec = 0;
    for (int i = 0; i < 300; i++) begin
      v6 = 1'b1; s6 = 3'd7; d6 = 16'(i);
      @(negedge clk);
      if (!r6) nr++;
      if (i > 0 && e6) ec++;
      if (i == 10) check("drop_cnt_mid", 64'(dc6), 64'd10);
      step();
    end
    v6 = 1'b0;
    @(negedge clk);
    if (e6) ec++;
    check("drop_not_ready_cycles", 64'(nr), 64'd0);
    check("drop_err_pulses", 64'(ec), 64'd300);
    check("drop_cnt_sat", 64'(dc6), 64'd255);
    check("drop_no_valid", 64'(ov6), 64'h0);
    step();
    @(negedge clk);
    check("drop_err_end", 64'(e6), 64'h0);
    check("drop_cnt_hold", 64'(dc6), 64'd255);

    // Mid-cycle reset with slots 0-2 full.
    step();
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, 3'(i), 16'h0A00 + 16'(i), 1'b0);
      push(i, 16'h0A00 + 16'(i));
      step();
    end
    drive8(1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 64'(ov8), 64'h07);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(ov8), 64'h0);
    check("async_rst_data",  64'(slot8(0)), 64'h0);
    check("async_rst_drop",  64'(dc6), 64'h0);
    exp_q.delete();
    #6 rst_n = 1'b1;
    drive8(1'b1, 3'd1, 16'h7777, 1'b0);
    @(negedge clk);
    check("post_rst_ready", 64'(r8), 64'h1);
    push(1, 16'h7777);
    step();
    drive8(1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    check("post_rst_valid", 64'(ov8), 64'h02);
    check("post_rst_data",  64'(slot8(1)), 64'h7777);
    step();
    or8 = 8'h02;
    step();
    or8 = '0;
    @(negedge clk);
    check("dut8_err_quiet", 64'(e8), 64'h0);
    check("dut8_drop_zero", 64'(dc8), 64'h0);
    check("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
